// File: rtl/circular_buffer.sv
// Three-row circular line buffer presenting a registered 3x3 pixel window and binary kernel.
// Optional window_valid output enabled by defining CIRCULAR_BUFFER_VALID_OUT_EN.
module circular_buffer #(
   parameter int PIX_W        = 6,
   parameter int PIX_PER_WORD = 4,
   parameter int ROWS         = 3
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [PIX_W*PIX_PER_WORD-1:0] data_in,
   input  logic [8:0]                    weight_in,
   input  logic                          buffer_weight_fire,
   input  logic                          buffer_data_fire,
   input  logic                          buffer_done,
   output logic [PIX_W-1:0]              x11,
   output logic [PIX_W-1:0]              x12,
   output logic [PIX_W-1:0]              x13,
   output logic [PIX_W-1:0]              x21,
   output logic [PIX_W-1:0]              x22,
   output logic [PIX_W-1:0]              x23,
   output logic [PIX_W-1:0]              x31,
   output logic [PIX_W-1:0]              x32,
   output logic [PIX_W-1:0]              x33,
`ifdef CIRCULAR_BUFFER_VALID_OUT_EN
   output logic                          window_valid,
`endif
   output logic                          w11,
   output logic                          w12,
   output logic                          w13,
   output logic                          w21,
   output logic                          w22,
   output logic                          w23,
   output logic                          w31,
   output logic                          w32,
   output logic                          w33
);

   localparam int WORD_W = PIX_W * PIX_PER_WORD;

   logic [WORD_W-1:0] row_q [ROWS];
   logic [WORD_W-1:0] row_d [ROWS];
   logic [1:0]        wp_q, wp_d;
   logic [1:0]        cnt_q, cnt_d;
   logic              ph_q, ph_d;
   logic [PIX_W-1:0]  x_q [9];
   logic [PIX_W-1:0]  x_d [9];
   logic [8:0]        w_q, w_d;
   logic              vld_q, vld_d;

   logic [1:0]        prev_idx;
   logic [1:0]        old_idx;
   logic [WORD_W-1:0] win_row [3];

   always_comb begin
      prev_idx = (wp_q == 2'd0) ? 2'd2 : wp_q - 2'd1;
      old_idx  = (wp_q == 2'd2) ? 2'd0 : wp_q + 2'd1;
      win_row[0] = row_q[old_idx];
      win_row[1] = row_q[prev_idx];
      win_row[2] = data_in;
   end

   always_comb begin
      row_d = row_q;
      wp_d  = wp_q;
      cnt_d = cnt_q;
      ph_d  = ph_q;
      x_d   = x_q;
      w_d   = w_q;
      vld_d = 1'b0;
      if (rst_n) begin
         for (int r = 0; r < ROWS; r++) row_d[r] = '0;
         for (int i = 0; i < 9; i++) x_d[i] = '0;
         wp_d  = 2'd0;
         cnt_d = 2'd0;
         ph_d  = 1'b0;
         w_d   = 9'd0;
      end else begin
         if (buffer_weight_fire && !buffer_data_fire) w_d = weight_in;
         if (buffer_done) begin
            for (int i = 0; i < 9; i++) x_d[i] = '0;
            wp_d  = 2'd0;
            cnt_d = 2'd0;
            ph_d  = 1'b0;
         end else if (buffer_data_fire) begin
            row_d[wp_q] = data_in;
            wp_d  = (wp_q == 2'd2) ? 2'd0 : wp_q + 2'd1;
            cnt_d = (cnt_q == 2'd3) ? 2'd3 : cnt_q + 2'd1;
            // Window slides by one pixel column pair: ph=0 takes P3..P1, ph=1 P2..P0.
            if (cnt_q >= 2'd2) begin
               for (int r = 0; r < 3; r++) begin
                  for (int c = 0; c < 3; c++) begin
                     x_d[r*3+c] = win_row[r][(3-c-int'(ph_q))*PIX_W +: PIX_W];
                  end
               end
               ph_d  = ~ph_q;
               vld_d = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      row_q <= row_d;
      wp_q  <= wp_d;
      cnt_q <= cnt_d;
      ph_q  <= ph_d;
      x_q   <= x_d;
      w_q   <= w_d;
      vld_q <= vld_d;
   end

   assign x11 = x_q[0];
   assign x12 = x_q[1];
   assign x13 = x_q[2];
   assign x21 = x_q[3];
   assign x22 = x_q[4];
   assign x23 = x_q[5];
   assign x31 = x_q[6];
   assign x32 = x_q[7];
   assign x33 = x_q[8];

   assign {w11, w12, w13, w21, w22, w23, w31, w32, w33} = w_q;

`ifdef CIRCULAR_BUFFER_VALID_OUT_EN
   assign window_valid = vld_q;
`else
   logic unused_vld;
   assign unused_vld = vld_q;
`endif

endmodule

// File: tb/tb_circular_buffer.sv
// Scoreboard bench for circular_buffer: stimulus queues expected windows,
// a negedge monitor pops and compares them.
module tb_circular_buffer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [23:0] data_in;
   logic [8:0]  weight_in;
   logic        buffer_weight_fire;
   logic        buffer_data_fire;
   logic        buffer_done;
   logic [5:0]  x11, x12, x13, x21, x22, x23, x31, x32, x33;
   logic        w11, w12, w13, w21, w22, w23, w31, w32, w33;
   logic        window_valid;

   always #5 clk = ~clk;

   circular_buffer dut (
      .clk                (clk),
      .rst_n              (rst_n),
      .data_in            (data_in),
      .weight_in          (weight_in),
      .buffer_weight_fire (buffer_weight_fire),
      .buffer_data_fire   (buffer_data_fire),
      .buffer_done        (buffer_done),
      .x11 (x11), .x12 (x12), .x13 (x13),
      .x21 (x21), .x22 (x22), .x23 (x23),
      .x31 (x31), .x32 (x32), .x33 (x33),
`ifdef CIRCULAR_BUFFER_VALID_OUT_EN
      .window_valid (window_valid),
`endif
      .w11 (w11), .w12 (w12), .w13 (w13),
      .w21 (w21), .w22 (w22), .w23 (w23),
      .w31 (w31), .w32 (w32), .w33 (w33)
   );

`ifndef CIRCULAR_BUFFER_VALID_OUT_EN
   assign window_valid = 1'b0;
`endif

   typedef struct {
      string      name;
      int         cyc;
      logic [53:0] x;
      logic [8:0] w;
      logic       v;
   } exp_t;

   exp_t exp_q[$];
   int   edge_cnt = 0;
   int   checks   = 0;
   int   failures = 0;

   logic [53:0] x_all;
   logic [8:0]  w_all;
   assign x_all = {x11, x12, x13, x21, x22, x23, x31, x32, x33};
   assign w_all = {w11, w12, w13, w21, w22, w23, w31, w32, w33};

   always @(posedge clk) edge_cnt++;

   function automatic logic [53:0] mkx(input int a, b, c, d, e, f, g, h, i);
      mkx = {6'(a), 6'(b), 6'(c), 6'(d), 6'(e), 6'(f), 6'(g), 6'(h), 6'(i)};
   endfunction

   always @(negedge clk) begin
      while (exp_q.size() > 0 && exp_q[0].cyc <= edge_cnt) begin
         exp_t e;
         e = exp_q.pop_front();
         checks++;
         if (x_all !== e.x) begin
            failures++;
            $display("FAIL %s x: got=%h exp=%h", e.name, x_all, e.x);
         end
         checks++;
         if (w_all !== e.w) begin
            failures++;
            $display("FAIL %s w: got=%h exp=%h", e.name, w_all, e.w);
         end
`ifdef CIRCULAR_BUFFER_VALID_OUT_EN
         checks++;
         if (window_valid !== e.v) begin
            failures++;
            $display("FAIL %s valid: got=%b exp=%b", e.name, window_valid, e.v);
         end
`endif
      end
   end

   task automatic step(input logic r, input logic df, input logic wf,
                       input logic dn, input logic [23:0] d,
                       input logic [8:0] wi, input string name,
                       input logic [53:0] ex, input logic [8:0] ew,
                       input logic ev);
      exp_t e;
      rst_n              = r;
      buffer_data_fire   = df;
      buffer_weight_fire = wf;
      buffer_done        = dn;
      data_in            = d;
      weight_in          = wi;
      @(posedge clk);
      #1;
      e.name = name;
      e.cyc  = edge_cnt;
      e.x    = ex;
      e.w    = ew;
      e.v    = ev;
      exp_q.push_back(e);
   endtask

   localparam logic [23:0] W1 = 24'h103081;
   localparam logic [23:0] W2 = 24'h206102;
   localparam logic [23:0] W3 = 24'h309183;
   localparam logic [23:0] W4 = 24'h406144;

   initial begin
      logic [53:0] z;
      logic [53:0] win_a;
      logic [53:0] win_b;
      logic [53:0] win_c;
      logic [53:0] win_d;
      z     = '0;
      win_a = mkx(4, 3, 2, 8, 6, 4, 12, 9, 6);
      win_b = mkx(6, 4, 2, 9, 6, 3, 6, 5, 4);
      win_c = mkx(4, 3, 2, 4, 3, 2, 4, 3, 2);
      win_d = mkx(3, 2, 1, 3, 2, 1, 3, 2, 1);
      rst_n = 1'b1; buffer_data_fire = 0; buffer_weight_fire = 0;
      buffer_done = 0; data_in = 0; weight_in = 0;
      @(posedge clk);
      #1;

      step(1, 0, 0, 0, 0,  0,      "reset",      z, 9'h000, 0);
      step(0, 1, 0, 0, W1, 0,      "one_word",   z, 9'h000, 0);
      step(0, 0, 1, 0, 0,  9'h155, "wload_155",  z, 9'h155, 0);
      step(0, 0, 1, 0, 0,  9'h0AA, "wload_0aa",  z, 9'h0AA, 0);
      step(0, 0, 0, 1, 0,  0,      "flush0",     z, 9'h0AA, 0);

      step(0, 1, 1, 0, W1, 9'h1FF, "acc1_wblk",  z,     9'h0AA, 0);
      step(0, 1, 0, 0, W2, 0,      "acc2",       z,     9'h0AA, 0);
      step(0, 1, 0, 0, W3, 0,      "acc3_win",   win_a, 9'h0AA, 1);
      step(0, 1, 0, 0, W4, 0,      "acc4_wrap",  win_b, 9'h0AA, 1);
      for (int i = 0; i < 5; i++)
         step(0, 0, 0, 0, 24'hFFFFFF, 0, "hold", win_b, 9'h0AA, 0);

      step(0, 1, 0, 1, W4, 0,      "done_flush", z,     9'h0AA, 0);
      step(0, 1, 0, 0, W1, 0,      "re_acc1",    z,     9'h0AA, 0);
      step(0, 1, 0, 0, W2, 0,      "re_acc2",    z,     9'h0AA, 0);
      step(0, 1, 0, 0, W3, 0,      "re_acc3",    win_a, 9'h0AA, 1);

      step(0, 0, 0, 1, 0,  0,      "flush2",     z,     9'h0AA, 0);
      for (int k = 1; k <= 32; k++) begin
         if (k < 3)
            step(0, 1, 0, 0, W1, 0, "const_fill", z, 9'h0AA, 0);
         else if (((k - 3) % 2) == 0)
            step(0, 1, 0, 0, W1, 0, "const_ph0", win_c, 9'h0AA, 1);
         else
            step(0, 1, 0, 0, W1, 0, "const_ph1", win_d, 9'h0AA, 1);
      end

      step(1, 1, 1, 0, W2, 9'h1FF, "mid_reset", z, 9'h000, 0);
      step(0, 1, 0, 0, W2, 0,      "post_rst1", z, 9'h000, 0);
      step(0, 1, 0, 0, W3, 0,      "post_rst2", z, 9'h000, 0);

      buffer_data_fire = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL drain: pending=%0d exp=0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: sim did not finish");
      $fatal(1);
   end

endmodule
